// File: rtl/mem_arbiter.sv
// Byte-wide RAM port sequencer shared by the icache miss path and the load/store buffer.
// Splits 1/2/4-byte accesses into per-byte RAM cycles, arbitrates round-robin, and handles IO stalls and flushes.
module mem_arbiter #(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        inst_miss,
  input  logic [31:0] inst_addr,
  output logic        inst_rdy,
  output logic [31:0] inst_data,
  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [1:0]  lsb_size,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;
  typedef enum logic {GRANT_INST, GRANT_LSB} grant_t;

  state_t      state_q, state_d;
  grant_t      last_q, last_d;
  logic [2:0]  k_q, k_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic        io_q, io_d;
  logic        inst_rdy_q, inst_rdy_d;
  logic        lsb_done_q, lsb_done_d;
  logic [31:0] a_live, a_hold_q;
  logic        wr_live;
  logic        stall;
  logic        avail_inst, avail_lsb, pick_lsb;
  logic [1:0]  lane;

  assign stall = io_q & io_buffer_full;
  // Byte on mem_din belongs to the address of the previous cycle, i.e. lane k-1.
  assign lane  = k_q[1:0] - 2'd1;

  // A requester whose done pulse is visible this cycle has already been served.
  assign avail_inst = inst_miss & ~inst_rdy_q;
  assign avail_lsb  = lsb_req & ~lsb_done_q;
  assign pick_lsb   = avail_lsb & (~avail_inst | (last_q == GRANT_INST));

  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a missed branch would otherwise infer a latch.
    a_live   = '0;
    wr_live  = 1'b0;
    mem_dout = '0;
    case (state_q)
      IFETCH, LOAD: begin
        if (k_q < len_q) a_live = base_q + {29'd0, k_q};
      end
      STORE: begin
        a_live   = base_q + {29'd0, k_q};
        wr_live  = ~stall;
        mem_dout = wdata_q[8*k_q[1:0] +: 8];
      end
      default: ;
    endcase
  end

  // While frozen, the RAM keeps seeing the last active address, so the byte it returns is still the one owed.
  assign mem_a     = rdy ? a_live : a_hold_q;
  assign mem_wr    = rdy & wr_live;
  assign inst_rdy  = inst_rdy_q;
  assign lsb_done  = lsb_done_q;
  assign inst_data = data_q;
  assign lsb_rdata = data_q;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    k_d        = k_q;
    len_d      = len_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    io_d       = io_q;
    inst_rdy_d = 1'b0;
    lsb_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush && (avail_inst || avail_lsb)) begin
          k_d    = '0;
          data_d = '0;
          if (pick_lsb) begin
            last_d  = GRANT_LSB;
            base_d  = lsb_addr;
            wdata_d = lsb_wdata;
            io_d    = (lsb_addr[17:16] == IO_HI);
            state_d = lsb_wr ? STORE : LOAD;
            case (lsb_size)
              2'd0:    len_d = 3'd1;
              2'd1:    len_d = 3'd2;
              default: len_d = 3'd4;
            endcase
          end else begin
            last_d  = GRANT_INST;
            base_d  = inst_addr;
            io_d    = 1'b0;
            len_d   = 3'd4;
            state_d = IFETCH;
          end
        end
      end
      IFETCH, LOAD: begin
        // IO reads have side effects, so once started they run to completion.
        if (flush && !(state_q == LOAD && io_q)) begin
          state_d = IDLE;
          data_d  = '0;
        end else begin
          if (k_q != 3'd0) data_d[8*lane +: 8] = mem_din;
          if (k_q == len_q) begin
            state_d = IDLE;
            if (state_q == IFETCH) inst_rdy_d = 1'b1;
            else                   lsb_done_d = 1'b1;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      STORE: begin
        if (!stall) begin
          if (k_q == len_q - 3'd1) begin
            state_d    = IDLE;
            lsb_done_d = 1'b1;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state_q    <= IDLE;
      last_q     <= GRANT_LSB;
      k_q        <= '0;
      len_q      <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      io_q       <= 1'b0;
      inst_rdy_q <= 1'b0;
      lsb_done_q <= 1'b0;
    end else if (rdy) begin
      state_q    <= state_d;
      last_q     <= last_d;
      k_q        <= k_d;
      len_q      <= len_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      io_q       <= io_d;
      inst_rdy_q <= inst_rdy_d;
      lsb_done_q <= lsb_done_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) a_hold_q <= '0;
    else      a_hold_q <= mem_a;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction vector table plus hand-written
// sequences for contention, IO stall, flush and reset; byte RAM model with one-cycle read latency.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        inst_miss = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_rdy;
  logic [31:0] inst_data;
  logic        lsb_req = 1'b0;
  logic        lsb_wr = 1'b0;
  logic [1:0]  lsb_size = '0;
  logic [31:0] lsb_addr = '0;
  logic [31:0] lsb_wdata = '0;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  mem_arbiter #(.IO_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .inst_miss(inst_miss), .inst_addr(inst_addr), .inst_rdy(inst_rdy), .inst_data(inst_data),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // RAM: written bytes live in ram, everything else comes from the seed image.
  logic [7:0] ram [int unsigned];

  function automatic logic [7:0] seed_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h13;
      32'h0000_0101: return 8'h05;
      32'h0000_0200: return 8'h11;
      32'h0000_0201: return 8'h22;
      32'h0000_0202: return 8'h33;
      32'h0000_0203: return 8'h44;
      32'h0000_0204: return 8'h55;
      32'h0000_0205: return 8'h9a;
      32'hffff_ffff: return 8'he1;
      32'h0000_0000: return 8'h5a;
      default:       return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return seed_byte(a);
  endfunction

  always @(posedge clk) begin
    mem_din <= rd(mem_a);
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  logic overlap = 1'b0;
  always @(negedge clk) if (inst_rdy && lsb_done) overlap <= 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_inst;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          flush_at;
    int          rdy_at;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  // Enter at posedge+1 with the block idle; leave at posedge+1 of the second cycle after done.
  task automatic do_txn(input vec_t v, output logic [31:0] data, output int lat,
                        output int nwr, output int npulse, output logic [31:0] a1);
    logic dn;
    if (v.is_inst) begin
      inst_miss = 1'b1; inst_addr = v.addr;
    end else begin
      lsb_req = 1'b1; lsb_wr = v.wr; lsb_size = v.size; lsb_addr = v.addr; lsb_wdata = v.wdata;
    end
    data = '0; lat = -1; nwr = 0; npulse = 0; a1 = '0;
    for (int c = 0; c < 40; c++) begin
      flush = (c == v.flush_at);
      rdy   = !(c >= v.rdy_at && c < v.rdy_at + 2);
      @(negedge clk);
      dn = v.is_inst ? inst_rdy : lsb_done;
      if (c == 1) a1 = mem_a;
      if (mem_wr) nwr++;
      if (dn) begin
        npulse++;
        if (lat < 0) begin
          lat  = c;
          data = v.is_inst ? inst_data : lsb_rdata;
        end
      end
      @(posedge clk); #1;
      if (lat >= 0 && c == lat) begin inst_miss = 1'b0; lsb_req = 1'b0; end
      if (lat >= 0 && c == lat + 1) break;
    end
    flush = 1'b0; rdy = 1'b1; inst_miss = 1'b0; lsb_req = 1'b0;
  endtask

  task automatic run_tie(input logic [31:0] iaddr, input logic [31:0] laddr,
                         output logic [31:0] a1, output logic [31:0] a7, output int ti, output int tl,
                         output logic [31:0] idat, output logic [31:0] ldat);
    inst_miss = 1'b1; inst_addr = iaddr;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd2; lsb_addr = laddr;
    ti = -1; tl = -1; a1 = '0; a7 = '0; idat = '0; ldat = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 1) a1 = mem_a;
      if (c == 7) a7 = mem_a;
      if (inst_rdy && ti < 0) begin ti = c; idat = inst_data; end
      if (lsb_done && tl < 0) begin tl = c; ldat = lsb_rdata; end
      @(posedge clk); #1;
      if (ti == c) inst_miss = 1'b0;
      if (tl == c) lsb_req = 1'b0;
      if (ti >= 0 && tl >= 0) break;
    end
    inst_miss = 1'b0; lsb_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[14];
    vec_t        fv;
    logic [31:0] data, a1, a7, idat, ldat, a4, a5;
    int          lat, nwr, npulse, ti, tl, ndone, nwr_stall;
    logic        wr_s[10];
    logic        dn_s[10];
    logic [31:0] a_s[10];
    logic [7:0]  d_s[10];

    //            inst  wr    size  addr           wdata          fl  rdy  exp_data       lat wr
    vecs[0]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0,         -1, -9, 32'h0000_0513, 6, 0};
    vecs[1]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0200, 32'h0,         -1, -9, 32'h4433_2211, 6, 0};
    vecs[2]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0205, 32'h0,         -1, -9, 32'h0000_009a, 3, 0};
    vecs[3]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0203, 32'h0,         -1, -9, 32'h0000_5544, 4, 0};
    vecs[4]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0200, 32'h0,         -1, -9, 32'h4433_2211, 6, 0};
    vecs[5]  = '{1'b0, 1'b0, 2'd1, 32'hffff_ffff, 32'h0,         -1, -9, 32'h0000_5ae1, 4, 0};
    vecs[6]  = '{1'b0, 1'b1, 2'd2, 32'h0000_1000, 32'hcafe_f00d,  2, -9, 32'h0,         5, 4};
    vecs[7]  = '{1'b0, 1'b0, 2'd2, 32'h0000_1000, 32'h0,         -1, -9, 32'hcafe_f00d, 6, 0};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 32'h0000_1010, 32'h1234_5678, -1, -9, 32'h0,         2, 1};
    vecs[9]  = '{1'b0, 1'b0, 2'd1, 32'h0000_100f, 32'h0,         -1, -9, 32'h0000_7800, 4, 0};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 32'h0003_0000, 32'h0,          1, -9, 32'h0000_00cd, 3, 0};
    vecs[11] = '{1'b0, 1'b0, 2'd2, 32'h0000_0200, 32'h0,         -1,  3, 32'h4433_2211, 8, 0};
    vecs[12] = '{1'b0, 1'b1, 2'd2, 32'h0000_1020, 32'h0102_0304, -1,  2, 32'h0,         7, 4};
    vecs[13] = '{1'b0, 1'b0, 2'd2, 32'h0000_1020, 32'h0,         -1, -9, 32'h0102_0304, 6, 0};

    // Reset state
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_ctl", 32'({mem_wr, inst_rdy, lsb_done}), 32'h0);
    check("rst_dout", 32'(mem_dout), 32'h0);
    check("rst_data", inst_data | lsb_rdata, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Tie straight after reset: ifetch first, load granted in the fetch's done cycle
    run_tie(32'h100, 32'h200, a1, a7, ti, tl, idat, ldat);
    check("tie1_first_addr", a1, 32'h100);
    check("tie1_inst_lat", 32'(ti), 32'd6);
    check("tie1_inst_data", idat, 32'h0000_0513);
    check("tie1_second_addr", a7, 32'h200);
    check("tie1_lsb_lat", 32'(tl), 32'd12);
    check("tie1_lsb_data", ldat, 32'h4433_2211);

    // Lone ifetch, then another tie: LSB wins this time
    do_txn(vecs[0], data, lat, nwr, npulse, a1);
    check("solo_fetch_lat", 32'(lat), 32'd6);
    run_tie(32'h100, 32'h200, a1, a7, ti, tl, idat, ldat);
    check("tie2_first_addr", a1, 32'h200);
    check("tie2_lsb_lat", 32'(tl), 32'd6);
    check("tie2_second_addr", a7, 32'h100);
    check("tie2_inst_lat", 32'(ti), 32'd12);
    check("tie2_inst_data", idat, 32'h0000_0513);

    // Half store to IO space with the output buffer full for three cycles
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd1; lsb_addr = 32'h0003_0000; lsb_wdata = 32'h0000_abcd;
    for (int c = 0; c < 10; c++) begin
      io_buffer_full = (c >= 1 && c <= 3);
      @(negedge clk);
      wr_s[c] = mem_wr; a_s[c] = mem_a; d_s[c] = mem_dout; dn_s[c] = lsb_done;
      @(posedge clk); #1;
      if (c == 6) lsb_req = 1'b0;
    end
    io_buffer_full = 1'b0;
    ndone = 0;
    nwr_stall = 0;
    for (int c = 0; c < 10; c++) begin
      if (dn_s[c]) ndone++;
      if (wr_s[c]) nwr_stall++;
    end
    check("io_stall_wr_low", 32'({wr_s[1], wr_s[2], wr_s[3]}), 32'h0);
    check("io_stall_addr", a_s[2], 32'h0003_0000);
    check("io_wr0", {wr_s[4], d_s[4], a_s[4][23:0]}, {1'b1, 8'hcd, 24'h03_0000});
    check("io_wr1", {wr_s[5], d_s[5], a_s[5][23:0]}, {1'b1, 8'hab, 24'h03_0001});
    check("io_done_cycle", 32'(dn_s[6]), 32'h1);
    check("io_done_count", 32'(ndone), 32'd1);
    check("io_wr_count", 32'(nwr_stall), 32'd2);
    check("io_ram", {16'h0, rd(32'h0003_0001), rd(32'h0003_0000)}, 32'h0000_abcd);

    // Flush in the middle of a fetch, then a fresh fetch from 0x200
    inst_miss = 1'b1; inst_addr = 32'h100;
    ti = -1; idat = '0; a4 = '1; a5 = '0;
    for (int c = 0; c < 13; c++) begin
      flush = (c == 3);
      if (c == 4) inst_addr = 32'h200;
      @(negedge clk);
      if (c == 4) a4 = mem_a;
      if (c == 5) a5 = mem_a;
      if (inst_rdy && ti < 0) begin ti = c; idat = inst_data; end
      @(posedge clk); #1;
      if (ti == c) inst_miss = 1'b0;
    end
    flush = 1'b0; inst_miss = 1'b0;
    check("flush_idle_addr", a4, 32'h0);
    check("flush_refetch_addr", a5, 32'h200);
    check("flush_refetch_lat", 32'(ti), 32'd10);
    check("flush_refetch_data", idat, 32'h4433_2211);

    // Transaction table
    for (int i = 0; i < 14; i++) begin
      do_txn(vecs[i], data, lat, nwr, npulse, a1);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_pulses", i), 32'(npulse), 32'd1);
      check($sformatf("v%0d_wr_count", i), 32'(nwr), 32'(vecs[i].exp_wr));
      check($sformatf("v%0d_first_addr", i), a1, vecs[i].addr);
      if (!vecs[i].wr) check($sformatf("v%0d_data", i), data, vecs[i].exp_data);
    end
    check("store_bytes_1020", {rd(32'h1023), rd(32'h1022), rd(32'h1021), rd(32'h1020)}, 32'h0102_0304);

    // Asynchronous reset in the middle of a word store
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd2; lsb_addr = 32'h1040; lsb_wdata = 32'h1122_3344;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_mid_store_mem", {mem_a[23:0], mem_dout}, 32'h0);
    check("rst_mid_store_ctl", 32'({mem_wr, inst_rdy, lsb_done}), 32'h0);
    check("rst_mid_store_data", inst_data | lsb_rdata, 32'h0);
    lsb_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_partial_bytes", {16'h0, rd(32'h1041), rd(32'h1040)}, 32'h0000_0044);
    fv = vecs[0];
    do_txn(fv, data, lat, nwr, npulse, a1);
    check("post_rst_fetch_lat", 32'(lat), 32'd6);
    check("post_rst_fetch_data", data, 32'h0000_0513);

    check("done_overlap", 32'(overlap), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
